uart_cmd_parser: RTL and testbench



---
 rtl/uart_cmd_pkg.sv | 38 +++
 rtl/cmd_timeout_timer.sv | 42 ++++
 rtl/uart_cmd_parser.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ---------------------------------------------------------------------------
// uart_cmd_pkg
// Shared definitions for the UART command parser:
//   - state_type   : parser FSM states (CHKSUM only exists when the
//                    CMD_CHECKSUM_EN macro is defined)
//   - ERR_*        : values reported on err_code
//   - OP_RW_BIT / OP_LEN_MSB : opcode byte field positions
//   - len_ok()     : checks the opcode byte count against MAX_BYTES
// ---------------------------------------------------------------------------
package uart_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_OPCODE = 3'd2,
    ST_DATA   = 3'd3,
`ifdef CMD_CHECKSUM_EN
    ST_CHKSUM = 3'd4,
`endif
    ST_STOP   = 3'd5
  } state_type;

  localparam logic [2:0] ERR_NONE         = 3'd0;
  localparam logic [2:0] ERR_BAD_OPCODE   = 3'd1;
  localparam logic [2:0] ERR_BAD_STOP     = 3'd2;
  localparam logic [2:0] ERR_BAD_CHECKSUM = 3'd3;
  localparam logic [2:0] ERR_OVERFLOW     = 3'd4;

  // Opcode byte layout: [7] = rw (1 = write), [6:0] = byte count.
  localparam int OP_RW_BIT  = 7;
  localparam int OP_LEN_MSB = 6;

  // A byte count is usable when it is 1..max_bytes.
  function automatic logic len_ok(input logic [OP_LEN_MSB:0] len, input int max_bytes);
    return (len != '0) && (int'(len) <= max_bytes);
  endfunction

endpackage

// File: rtl/cmd_timeout_timer.sv
// ---------------------------------------------------------------------------
// cmd_timeout_timer
// Inactivity counter for the command parser.
// Ports:
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   clear  in  restart the count (byte received, or parser idle)
//   run    in  count one cycle of inactivity
//   expire out high during the cycle in which the count has reached
//              TIMEOUT_CYCLES-1 with no clear; the parser aborts on the
//              following edge
// ---------------------------------------------------------------------------
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
  // clear has priority so a byte arriving on the terminal cycle wins.
  assign expire     = run && !clear && w_terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (clear || expire) begin
      r_count <= '0;
    end else if (run) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// uart_cmd_parser
// Parses framed command packets from a UART receiver:
//   START, ADDR, OPCODE, DATA x len (writes only), [CHKSUM], STOP
// and presents each validated packet as a one-cycle commit.
// Optional feature macro: CMD_CHECKSUM_EN -- adds a checksum byte (XOR of
// address, opcode and data bytes) between the payload and the stop byte.
// Ports:
//   clk            in   system clock
//   reset          in   asynchronous active-high reset
//   rx_done_tick   in   received_byte valid this cycle
//   received_byte  in   byte from UART receiver
//   buffers_full   in   downstream instruction buffers cannot accept
//   cmd_valid      out  one-cycle commit strobe
//   cmd_addr       out  I2C register pointer
//   cmd_rw         out  1 = write, 0 = read
//   cmd_len        out  byte count
//   cmd_data       out  write data, byte i at [8i+:8]
//   busy           out  parser not idle
//   time_out       out  one-cycle inactivity abort pulse
//   err_tick       out  one-cycle error pulse
//   err_code       out  last error code (held)
// ---------------------------------------------------------------------------
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] START_BYTE     = 8'hFF,
  parameter logic [7:0] STOP_BYTE      = 8'hFF,
  parameter int         MAX_BYTES      = 2,
  parameter int         TIMEOUT_CYCLES = 10,
  localparam int        LEN_W          = $clog2(MAX_BYTES + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_done_tick,
  input  logic [7:0]             received_byte,
  input  logic                   buffers_full,
  output logic                   cmd_valid,
  output logic [7:0]             cmd_addr,
  output logic                   cmd_rw,
  output logic [LEN_W-1:0]       cmd_len,
  output logic [8*MAX_BYTES-1:0] cmd_data,
  output logic                   busy,
  output logic                   time_out,
  output logic                   err_tick,
  output logic [2:0]             err_code
);

  // State entered once the opcode/data phase is complete.
`ifdef CMD_CHECKSUM_EN
  localparam state_type ST_AFTER_PAYLOAD = ST_CHKSUM;
`else
  localparam state_type ST_AFTER_PAYLOAD = ST_STOP;
`endif

  state_type              r_state;
  logic [LEN_W-1:0]       r_idx;
  logic                   r_cmd_valid;
  logic [7:0]             r_cmd_addr;
  logic                   r_cmd_rw;
  logic [LEN_W-1:0]       r_cmd_len;
  logic [8*MAX_BYTES-1:0] r_cmd_data;
  logic                   r_time_out;
  logic                   r_err_tick;
  logic [2:0]             r_err_code;
`ifdef CMD_CHECKSUM_EN
  logic [7:0]             r_xor;
`endif

  logic                   w_run;
  logic                   w_clear;
  logic                   w_expire;
  logic [OP_LEN_MSB:0]    w_op_len;
  logic                   w_op_rw;
  logic                   w_len_ok;
  logic                   w_last_data;
  logic [MAX_BYTES-1:0]   w_lane_we;
  logic [8*MAX_BYTES-1:0] w_data_next;

  assign w_run       = (r_state != ST_IDLE);
  // Counter only runs while a packet is open; any byte restarts it.
  assign w_clear     = rx_done_tick || !w_run;
  assign w_op_len    = received_byte[OP_LEN_MSB:0];
  assign w_op_rw     = received_byte[OP_RW_BIT];
  assign w_len_ok    = len_ok(w_op_len, MAX_BYTES);
  assign w_last_data = ((r_idx + LEN_W'(1)) == r_cmd_len);

  // Per-lane write enables: only the lane selected by the data index
  // takes the incoming byte, the others keep their contents.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_BYTES; gi++) begin : g_lane
      assign w_lane_we[gi] = (r_state == ST_DATA) && rx_done_tick &&
                             (r_idx == LEN_W'(gi));
      assign w_data_next[8*gi +: 8] = w_lane_we[gi] ? received_byte
                                                    : r_cmd_data[8*gi +: 8];
    end
  endgenerate

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (w_clear),
    .run    (w_run),
    .expire (w_expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_rw    <= 1'b0;
      r_cmd_len   <= '0;
      r_cmd_data  <= '0;
      r_time_out  <= 1'b0;
      r_err_tick  <= 1'b0;
      r_err_code  <= ERR_NONE;
`ifdef CMD_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      // Strobes default low so each fires for exactly one cycle.
      r_cmd_valid <= 1'b0;
      r_time_out  <= 1'b0;
      r_err_tick  <= 1'b0;

      if (rx_done_tick) begin
        case (r_state)
          ST_IDLE: begin
            if ((received_byte == START_BYTE) && !buffers_full) begin
              r_state    <= ST_ADDR;
              r_idx      <= '0;
              r_cmd_addr <= '0;
              r_cmd_rw   <= 1'b0;
              r_cmd_len  <= '0;
              r_cmd_data <= '0;
            end
          end

          ST_ADDR: begin
            r_cmd_addr <= received_byte;
`ifdef CMD_CHECKSUM_EN
            r_xor      <= received_byte;
`endif
            r_state    <= ST_OPCODE;
          end

          ST_OPCODE: begin
            if (!w_len_ok) begin
              r_err_tick <= 1'b1;
              r_err_code <= ERR_BAD_OPCODE;
              r_state    <= ST_IDLE;
            end else begin
              r_cmd_rw  <= w_op_rw;
              r_cmd_len <= LEN_W'(w_op_len);
              r_idx     <= '0;
`ifdef CMD_CHECKSUM_EN
              r_xor     <= r_xor ^ received_byte;
`endif
              r_state   <= w_op_rw ? ST_DATA : ST_AFTER_PAYLOAD;
            end
          end

          ST_DATA: begin
            r_cmd_data <= w_data_next;
            r_idx      <= r_idx + LEN_W'(1);
`ifdef CMD_CHECKSUM_EN
            r_xor      <= r_xor ^ received_byte;
`endif
            if (w_last_data) begin
              r_state <= ST_AFTER_PAYLOAD;
            end
          end

`ifdef CMD_CHECKSUM_EN
          ST_CHKSUM: begin
            if (received_byte == r_xor) begin
              r_state <= ST_STOP;
            end else begin
              r_err_tick <= 1'b1;
              r_err_code <= ERR_BAD_CHECKSUM;
              r_state    <= ST_IDLE;
            end
          end
`endif

          ST_STOP: begin
            if (received_byte != STOP_BYTE) begin
              r_err_tick <= 1'b1;
              r_err_code <= ERR_BAD_STOP;
            end else if (buffers_full) begin
              // Packet is well formed but nowhere to put it.
              r_err_tick <= 1'b1;
              r_err_code <= ERR_OVERFLOW;
            end else begin
              r_cmd_valid <= 1'b1;
            end
            r_state <= ST_IDLE;
          end

          default: r_state <= ST_IDLE;
        endcase
      end else if (w_expire) begin
        // Abort: cmd_* keep their partial contents, nothing is committed.
        r_time_out <= 1'b1;
        r_state    <= ST_IDLE;
      end
    end
  end

  assign cmd_valid = r_cmd_valid;
  assign cmd_addr  = r_cmd_addr;
  assign cmd_rw    = r_cmd_rw;
  assign cmd_len   = r_cmd_len;
  assign cmd_data  = r_cmd_data;
  assign busy      = w_run;
  assign time_out  = r_time_out;
  assign err_tick  = r_err_tick;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed and randomized packets for uart_cmd_parser (MAX_BYTES=2,
// TIMEOUT_CYCLES=10). Expected results are derived per packet from the
// framing rules; define CMD_CHECKSUM_EN to exercise the checksum build.
// ---------------------------------------------------------------------------
module tb_uart_cmd_parser;

  localparam int MAXB  = 2;
  localparam int TO    = 10;
  localparam int LEN_W = $clog2(MAXB + 1);

  logic                clk = 1'b0;
  logic                reset;
  logic                rx_done_tick;
  logic [7:0]          received_byte;
  logic                buffers_full;
  logic                cmd_valid;
  logic [7:0]          cmd_addr;
  logic                cmd_rw;
  logic [LEN_W-1:0]    cmd_len;
  logic [8*MAXB-1:0]   cmd_data;
  logic                busy;
  logic                time_out;
  logic                err_tick;
  logic [2:0]          err_code;

  uart_cmd_parser #(
    .START_BYTE     (8'hFF),
    .STOP_BYTE      (8'hFF),
    .MAX_BYTES      (MAXB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_done_tick  (rx_done_tick),
    .received_byte (received_byte),
    .buffers_full  (buffers_full),
    .cmd_valid     (cmd_valid),
    .cmd_addr      (cmd_addr),
    .cmd_rw        (cmd_rw),
    .cmd_len       (cmd_len),
    .cmd_data      (cmd_data),
    .busy          (busy),
    .time_out      (time_out),
    .err_tick      (err_tick),
    .err_code      (err_code)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Pulse counters sampled on the falling edge.
  int n_valid_seen = 0;
  int n_err_seen   = 0;
  int n_to_seen    = 0;
  always @(negedge clk) begin
    if (cmd_valid) n_valid_seen++;
    if (err_tick)  n_err_seen++;
    if (time_out)  n_to_seen++;
  end

  logic [2:0]  exp_err;     // err_code is sticky
  logic [7:0]  tx_q[$];     // bytes of the packet under test

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the byte is consumed.
  task automatic send_byte(input logic [7:0] b, input logic full);
    rx_done_tick  = 1'b1;
    received_byte = b;
    buffers_full  = full;
    @(posedge clk);
    #1;
    rx_done_tick  = 1'b0;
    buffers_full  = 1'b0;
  endtask

  task automatic send_ck(input logic [7:0] ck);
`ifdef CMD_CHECKSUM_EN
    send_byte(ck, 1'b0);
`else
    if (ck === 8'hxx) $display("unused checksum");
`endif
  endtask

  task automatic push_ck(input logic [7:0] ck);
`ifdef CMD_CHECKSUM_EN
    tx_q.push_back(ck);
`else
    if (ck === 8'hxx) $display("unused checksum");
`endif
  endtask

  // Sends tx_q and checks the outcome on the edge of the last byte plus
  // the pulse widths one cycle later.
  task automatic run_pkt(input string name, input bit full_last, input int gap_max,
                         input bit exp_commit, input logic [2:0] code,
                         input logic [7:0] a, input logic rw,
                         input logic [LEN_W-1:0] len, input logic [8*MAXB-1:0] data);
    int v0, e0, t0;
    v0 = n_valid_seen; e0 = n_err_seen; t0 = n_to_seen;
    for (int i = 0; i < tx_q.size(); i++) begin
      if (i > 0) idle($urandom_range(0, gap_max));
      send_byte(tx_q[i], (i == tx_q.size() - 1) ? full_last : 1'b0);
    end
    if (code != 3'd0) exp_err = code;
    check({name, ".cmd_valid"}, cmd_valid, exp_commit);
    check({name, ".err_tick"},  err_tick,  code != 3'd0);
    check({name, ".err_code"},  err_code,  exp_err);
    check({name, ".busy"},      busy,      1'b0);
    if (exp_commit) begin
      check({name, ".cmd_addr"}, cmd_addr, a);
      check({name, ".cmd_rw"},   cmd_rw,   rw);
      check({name, ".cmd_len"},  cmd_len,  len);
      check({name, ".cmd_data"}, cmd_data, data);
    end
    idle(1);
    check({name, ".valid_cnt"}, n_valid_seen - v0, exp_commit ? 1 : 0);
    check({name, ".err_cnt"},   n_err_seen - e0,   (code != 3'd0) ? 1 : 0);
    check({name, ".to_cnt"},    n_to_seen - t0,    0);
    $display("pkt %s: bytes=%0d commit=%0d code=%0d addr=%02h data=%04h",
             name, tx_q.size(), exp_commit, code, cmd_addr, cmd_data);
  endtask

  // Random-packet variables
  int               mode, len;
  logic             rw;
  logic [7:0]       a, op, ck, stop, d;
  logic [8*MAXB-1:0] data;
  logic [2:0]       code;
  bit               commit, full_last;
  int               v0, t0;

  initial begin
    reset         = 1'b1;
    rx_done_tick  = 1'b0;
    received_byte = 8'h00;
    buffers_full  = 1'b0;
    exp_err       = 3'd0;

    // Reset state
    idle(2);
    check("rst.cmd_valid", cmd_valid, 0);
    check("rst.busy",      busy,      0);
    check("rst.cmd_addr",  cmd_addr,  0);
    check("rst.cmd_data",  cmd_data,  0);
    check("rst.err_code",  err_code,  0);
    check("rst.time_out",  time_out,  0);
    reset = 1'b0;
    idle(1);

    // Write of 1 byte
    tx_q = {8'hFF, 8'h04, 8'h81, 8'h30};
    push_ck(8'h04 ^ 8'h81 ^ 8'h30);
    tx_q.push_back(8'hFF);
    run_pkt("wr1", 0, 0, 1, 3'd0, 8'h04, 1'b1, 1, 16'h0030);

    // Write of 2 bytes
    tx_q = {8'hFF, 8'h04, 8'h82, 8'h30, 8'h16};
    push_ck(8'hA0);
    tx_q.push_back(8'hFF);
    run_pkt("wr2", 0, 2, 1, 3'd0, 8'h04, 1'b1, 2, 16'h1630);

    // Read clears stale write data
    tx_q = {8'hFF, 8'h04, 8'h02};
    push_ck(8'h06);
    tx_q.push_back(8'hFF);
    run_pkt("rd", 0, 1, 1, 3'd0, 8'h04, 1'b0, 2, 16'h0000);

    // START while buffers full is ignored
    send_byte(8'hFF, 1'b1);
    check("full_start.busy", busy, 0);
    send_byte(8'h04, 1'b0);
    check("full_start.busy2", busy, 0);

    // Overflow at stop of a read
    tx_q = {8'hFF, 8'h09, 8'h01};
    push_ck(8'h08);
    tx_q.push_back(8'hFF);
    run_pkt("overflow", 1, 0, 0, 3'd4, 8'h09, 1'b0, 1, 16'h0);

    // Bad opcode (len > MAX_BYTES) and bad stop
    tx_q = {8'hFF, 8'h04, 8'h83};
    run_pkt("bad_op", 0, 0, 0, 3'd1, 8'h04, 1'b1, 0, 16'h0);
    tx_q = {8'hFF, 8'h04, 8'h80};
    run_pkt("bad_op0", 0, 0, 0, 3'd1, 8'h04, 1'b1, 0, 16'h0);
    tx_q = {8'hFF, 8'h04, 8'h01};
    push_ck(8'h05);
    tx_q.push_back(8'h00);
    run_pkt("bad_stop", 0, 0, 0, 3'd2, 8'h04, 1'b0, 1, 16'h0);

`ifdef CMD_CHECKSUM_EN
    tx_q = {8'hFF, 8'h04, 8'h82, 8'h30, 8'h16, 8'hA1};
    run_pkt("bad_ck", 0, 0, 0, 3'd3, 8'h04, 1'b1, 2, 16'h1630);
`endif

    // Inactivity timeout: pulse on the 10th edge after the address byte
    v0 = n_valid_seen; t0 = n_to_seen;
    send_byte(8'hFF, 1'b0);
    send_byte(8'h04, 1'b0);
    for (int i = 1; i < TO; i++) begin
      idle(1);
      check("to.early", time_out, 0);
    end
    idle(1);
    check("to.pulse",    time_out, 1);
    check("to.busy",     busy,     0);
    check("to.cmd_addr", cmd_addr, 8'h04);
    check("to.valid",    cmd_valid, 0);
    idle(1);
    check("to.one_cycle", time_out, 0);
    check("to.to_cnt",    n_to_seen - t0, 1);
    check("to.valid_cnt", n_valid_seen - v0, 0);
    $display("timeout: addr=%02h busy=%0d", cmd_addr, busy);

    // Byte on the terminal cycle beats the timeout
    send_byte(8'hFF, 1'b0);
    send_byte(8'h05, 1'b0);
    idle(TO - 1);
    send_byte(8'h81, 1'b0);
    check("tickwins.time_out", time_out, 0);
    check("tickwins.busy",     busy,     1);
    send_byte(8'h5A, 1'b0);
    send_ck(8'h05 ^ 8'h81 ^ 8'h5A);
    send_byte(8'hFF, 1'b0);
    check("tickwins.valid", cmd_valid, 1);
    check("tickwins.data",  cmd_data,  16'h005A);
    $display("tickwins: valid=%0d data=%04h", cmd_valid, cmd_data);

    // START on the cycle right after a commit
    send_byte(8'hFF, 1'b0);
    check("b2b.busy", busy, 1);
    check("b2b.addr_clr", cmd_addr, 0);
    check("b2b.valid_low", cmd_valid, 0);
    send_byte(8'h07, 1'b0);
    send_byte(8'h02, 1'b0);
    send_ck(8'h05);
    send_byte(8'hFF, 1'b0);
    check("b2b.valid", cmd_valid, 1);
    check("b2b.addr",  cmd_addr,  8'h07);
    check("b2b.rw",    cmd_rw,    0);
    $display("b2b: addr=%02h len=%0d", cmd_addr, cmd_len);
    idle(1);

    // Reset mid-packet
    send_byte(8'hFF, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h82, 1'b0);
    send_byte(8'h11, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("midrst.busy",     busy,     0);
    check("midrst.cmd_addr", cmd_addr, 0);
    check("midrst.cmd_len",  cmd_len,  0);
    check("midrst.cmd_data", cmd_data, 0);
    check("midrst.err_code", err_code, 0);
    $display("midrst: busy=%0d err_code=%0d", busy, err_code);
    @(negedge clk);
    reset   = 1'b0;
    exp_err = 3'd0;
    @(posedge clk);
    #1;

    // Randomized packets
    for (int p = 0; p < 60; p++) begin
      mode = $urandom_range(0, 9);
      a    = 8'($urandom);
      rw   = 1'($urandom_range(0, 1));
      len  = $urandom_range(1, MAXB);
      if (mode == 0) len = ($urandom_range(0, 1) == 1) ? 0 : MAXB + 1 + $urandom_range(0, 120);
      op        = {rw, 7'(len)};
      tx_q      = {8'hFF, a, op};
      data      = '0;
      code      = 3'd0;
      commit    = 0;
      full_last = 0;
      if (len == 0 || len > MAXB) begin
        code = 3'd1;
      end else begin
        ck = a ^ op;
        if (rw) begin
          for (int i = 0; i < len; i++) begin
            d = 8'($urandom);
            tx_q.push_back(d);
            data[8*i +: 8] = d;
            ck ^= d;
          end
        end
`ifdef CMD_CHECKSUM_EN
        if (mode == 1) begin
          tx_q.push_back(ck ^ (8'd1 << $urandom_range(0, 7)));
          code = 3'd3;
        end else begin
          tx_q.push_back(ck);
        end
`endif
        if (code == 3'd0) begin
          if (mode == 2) begin
            stop = 8'($urandom);
            if (stop == 8'hFF) stop = 8'h00;
            code = 3'd2;
          end else begin
            stop = 8'hFF;
            if (mode == 3) begin
              full_last = 1;
              code      = 3'd4;
            end else begin
              commit = 1;
            end
          end
          tx_q.push_back(stop);
        end
      end
      run_pkt($sformatf("rnd%0d", p), full_last, 3, commit, code, a, rw,
              LEN_W'(len), data);
      idle($urandom_range(0, 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
